// File: rtl/lfsr_checker.sv
// lfsr_checker: PRBS13 (x^13+x^12+x^11+x^8+1) self-synchronizing checker with lock/loss tracking
module lfsr_checker #(
    parameter int LOCK_CNT  = 32,
    parameter int WIN       = 64,
    parameter int LOSS_ERRS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inbit,
    input  logic        in_valid,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [31:0] bit_count
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN + 1);
    localparam int EW = $clog2(LOSS_ERRS + 1);
    typedef enum logic [1:0] {FILL, HUNT, LOCK} state_t;
    state_t state, state_n;
    logic [12:0] h, h_n;
    logic [3:0] fill_cnt, fill_n;
    logic [MW-1:0] match_cnt, match_n;
    logic [WW-1:0] win_cnt, win_n;
    logic [EW-1:0] win_err, werr_n;
    logic p, miss, chk;
    assign p = h[12] ^ h[11] ^ h[10] ^ h[7];
    assign miss = inbit != p;
    assign chk = in_valid && state == LOCK;
    assign locked = state == LOCK;
    always_comb begin
        state_n = state;
        h_n = h;
        fill_n = fill_cnt;
        match_n = match_cnt;
        win_n = win_cnt;
        werr_n = win_err;
        if (in_valid) begin
            case (state)
                FILL: begin
                    h_n = {h[11:0], inbit};
                    fill_n = fill_cnt + 1'b1;
                    if (fill_cnt == 4'd12) begin
                        state_n = HUNT;
                        fill_n = '0;
                        match_n = '0;
                    end
                end
                HUNT: begin
                    h_n = {h[11:0], inbit};
                    // an all-zero history would predict zeros forever, so it never builds confidence
                    match_n = (!miss && h != '0) ? match_cnt + 1'b1 : '0;
                    if (match_n == MW'(LOCK_CNT)) begin
                        state_n = LOCK;
                        match_n = '0;
                        win_n = '0;
                        werr_n = '0;
                    end
                end
                LOCK: begin
                    // free-run on our own prediction so a line error cannot poison later predictions
                    h_n = {h[11:0], p};
                    werr_n = win_err + EW'(miss);
                    if (werr_n == EW'(LOSS_ERRS)) begin
                        state_n = FILL;
                        h_n = '0;
                        fill_n = '0;
                        win_n = '0;
                        werr_n = '0;
                    end else if (win_cnt == WW'(WIN - 1)) begin
                        win_n = '0;
                        werr_n = '0;
                    end else begin
                        win_n = win_cnt + 1'b1;
                    end
                end
                default: state_n = FILL;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            h <= '0;
            fill_cnt <= '0;
            match_cnt <= '0;
            win_cnt <= '0;
            win_err <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            state <= state_n;
            h <= h_n;
            fill_cnt <= fill_n;
            match_cnt <= match_n;
            win_cnt <= win_n;
            win_err <= werr_n;
            err_pulse <= chk && miss;
            err_count <= clr_cnt ? '0 : (chk && miss && ~&err_count) ? err_count + 1'b1 : err_count;
            bit_count <= clr_cnt ? '0 : (chk && ~&bit_count) ? bit_count + 1'b1 : bit_count;
        end
    end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: scenario tasks plus randomized run against a sequence-level model of the checker
module tb_lfsr_checker;
    localparam int LOCK_CNT = 32;
    localparam int WIN = 64;
    localparam int LOSS_ERRS = 8;
    logic clk = 1'b0, rst = 1'b0, inbit = 1'b0, in_valid = 1'b0, clr_cnt = 1'b0;
    logic locked, err_pulse;
    logic [15:0] err_count;
    logic [31:0] bit_count;
    int errors = 0, checks = 0;
    bit gen[$];
    bit mh[$];
    int m_state, m_fill, m_match, m_win, m_werr;
    bit m_pulse;
    int m_err;
    longint m_bits;

    lfsr_checker #(.LOCK_CNT(LOCK_CNT), .WIN(WIN), .LOSS_ERRS(LOSS_ERRS)) dut (
        .clk(clk), .rst(rst), .inbit(inbit), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    function automatic bit gen_bit();
        bit b;
        b = gen[0] ^ gen[1] ^ gen[2] ^ gen[5];
        gen.push_back(b);
        void'(gen.pop_front());
        return b;
    endfunction

    function automatic void hpush(input bit x);
        mh.push_back(x);
        void'(mh.pop_front());
    endfunction

    function automatic void model_reset();
        mh.delete();
        repeat (13) mh.push_back(1'b0);
        m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
        m_pulse = 0; m_err = 0; m_bits = 0;
    endfunction

    // history queue holds b[t-13]..b[t-1] oldest first
    task automatic step(input bit v, input bit b, input bit c);
        bit p, e, nz, cnt;
        in_valid = v; inbit = b; clr_cnt = c;
        @(posedge clk);
        p = mh[0] ^ mh[1] ^ mh[2] ^ mh[5];
        e = 0; cnt = 0; nz = 0;
        foreach (mh[i]) nz |= mh[i];
        if (v) begin
            if (m_state == 0) begin
                hpush(b);
                m_fill++;
                if (m_fill == 13) begin m_state = 1; m_match = 0; end
            end else if (m_state == 1) begin
                m_match = (b == p && nz) ? m_match + 1 : 0;
                hpush(b);
                if (m_match == LOCK_CNT) begin m_state = 2; m_win = 0; m_werr = 0; end
            end else begin
                cnt = 1;
                e = b != p;
                hpush(p);
                m_werr += int'(e);
                if (m_werr == LOSS_ERRS) begin
                    m_state = 0; m_fill = 0; m_win = 0; m_werr = 0;
                    mh.delete();
                    repeat (13) mh.push_back(1'b0);
                end else if (++m_win == WIN) begin
                    m_win = 0; m_werr = 0;
                end
            end
        end
        m_pulse = e;
        if (c) begin
            m_err = 0; m_bits = 0;
        end else begin
            if (e && m_err != 65535) m_err++;
            if (cnt && m_bits != 64'hFFFF_FFFF) m_bits++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 1'($urandom); inbit = 1'($urandom); clr_cnt = 1'($urandom);
        @(posedge clk);
        model_reset();
        #1;
        rst = 0;
    endtask

    task automatic clean(input int n);
        repeat (n) step(1, gen_bit(), 0);
    endtask

    task automatic bad();
        step(1, ~gen_bit(), 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", err_pulse); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
        checks++; if (bit_count !== 32'd0) begin errors++; $display("FAIL reset_bitcnt: got %0d want 0", bit_count); end
    endtask

    task automatic test_lock_clean();
        do_reset();
        clean(44);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0 after 44 bits", locked); end
        clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_45: got %b want 1 after 45 bits", locked); end
        clean(20);
        checks++; if (bit_count !== 32'd20) begin errors++; $display("FAIL lock_bitcnt: got %0d want 20", bit_count); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL lock_errcnt: got %0d want 0", err_count); end
    endtask

    task automatic test_single_error();
        bad();
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse: got %b want 1", err_pulse); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_errcnt: got %0d want 1", err_count); end
        clean(1);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_end: got %b want 0", err_pulse); end
        checks++; if (locked !== 1'b1 || err_count !== 16'd1) begin errors++; $display("FAIL single_hold: locked %b errcnt %0d want 1/1", locked, err_count); end
    endtask

    task automatic test_loss();
        int e0;
        longint b0;
        for (int i = 0; i < 2 * WIN && (m_win != 0 || m_werr != 0); i++) clean(1);
        e0 = m_err; b0 = m_bits;
        for (int i = 0; i < 7; i++) begin bad(); clean(1); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_early: got %b want 1 after 7 errors", locked); end
        bad();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_drop: got %b want 0 after 8 errors", locked); end
        checks++; if (err_count !== 16'(e0 + 8)) begin errors++; $display("FAIL loss_errcnt: got %0d want %0d", err_count, e0 + 8); end
        checks++; if (bit_count !== 32'(b0 + 15)) begin errors++; $display("FAIL loss_bitcnt: got %0d want %0d", bit_count, b0 + 15); end
        clean(44);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early: got %b want 0", locked); end
        clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock: got %b want 1", locked); end
    endtask

    task automatic test_zero();
        bit seen;
        do_reset();
        seen = 0;
        repeat (200) begin
            step(1, 0, 0);
            seen |= locked | err_pulse | (|err_count) | (|bit_count);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL zero_input: outputs got nonzero want all 0"); end
    endtask

    task automatic test_toggle();
        logic [15:0] ec;
        do_reset();
        for (int i = 0; i < 45; i++) begin
            step(1, gen_bit(), 0);
            if (i == 43) begin
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL toggle_early: got %b want 0", locked); end
            end
            if (i == 44) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL toggle_lock: got %b want 1", locked); end
            end
            step(0, 1'($urandom), 0);
        end
        step(1, ~gen_bit(), 1);
        checks++; if (err_pulse !== 1'b1 || err_count !== 16'd0) begin errors++; $display("FAIL clr_vs_err: pulse %b errcnt %0d want 1/0", err_pulse, err_count); end
        checks++; if (bit_count !== 32'd0) begin errors++; $display("FAIL clr_bitcnt: got %0d want 0", bit_count); end
        bad();
        ec = err_count;
        step(0, 1'($urandom), 0);
        checks++; if (err_pulse !== 1'b0 || err_count !== ec || locked !== 1'b1) begin errors++; $display("FAIL idle_hold: pulse %b errcnt %0d locked %b want 0/%0d/1", err_pulse, err_count, locked, ec); end
    endtask

    task automatic test_rst_locked();
        step(1, gen_bit(), 1);
        repeat (5) begin bad(); clean(2); end
        checks++; if (err_count !== 16'd5 || locked !== 1'b1) begin errors++; $display("FAIL pre_rst: errcnt %0d locked %b want 5/1", err_count, locked); end
        do_reset();
        checks++; if (locked !== 1'b0 || err_count !== 16'd0 || bit_count !== 32'd0) begin errors++; $display("FAIL rst_locked: locked %b errcnt %0d bitcnt %0d want 0/0/0", locked, err_count, bit_count); end
        clean(44);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_refill_early: got %b want 0", locked); end
        clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rst_refill: got %b want 1", locked); end
    endtask

    task automatic test_random();
        bit v, b, c;
        int noise;
        do_reset();
        noise = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset();
            if ($urandom_range(0, 299) == 0) noise = 40;
            v = $urandom_range(0, 3) != 0;
            c = $urandom_range(0, 99) == 0;
            b = 1'($urandom);
            if (v) begin
                b = gen_bit();
                if (noise > 0) begin b = 1'($urandom); noise--; end
                else if ($urandom_range(0, 24) == 0) b = ~b;
            end
            step(v, b, c);
            checks++;
            if (locked !== (m_state == 2) || err_pulse !== m_pulse || err_count !== 16'(m_err) || bit_count !== 32'(m_bits)) begin
                errors++;
                $display("FAIL random cyc %0d: got l=%b p=%b e=%0d b=%0d want l=%b p=%b e=%0d b=%0d",
                         i, locked, err_pulse, err_count, bit_count, m_state == 2, m_pulse, m_err, m_bits);
            end
        end
    endtask

    initial begin
        repeat (13) gen.push_back(1'($urandom));
        gen[$urandom_range(0, 12)] = 1'b1;
        model_reset();
        test_reset();
        test_lock_clean();
        test_single_error();
        test_loss();
        test_zero();
        test_toggle();
        test_rst_locked();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_CNT, default 32: consecutive correct predictions after fill needed to declare lock.
REQ-002 Parameter WIN, default 64: length in valid bits of the loss-of-lock observation window.
REQ-003 Parameter LOSS_ERRS, default 8: errors within one window that force loss of lock.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 inbit  input  1  received PRBS bit.
REQ-007 in_valid  input  1  qualifies inbit; one bit consumed per cycle with in_valid=1.
REQ-008 clr_cnt  input  1  synchronous clear of err_count and bit_count.
REQ-009 locked  output  1  checker synchronized to incoming sequence.
REQ-010 err_pulse  output  1  one-cycle strobe per mismatched bit while locked.
REQ-011 err_count  output  16  saturating count of mismatches while locked.
REQ-012 bit_count  output  32  saturating count of bits checked while locked.

Function
REQ-013 Reference sequence SHALL be the 13-bit maximal-length PRBS x^13+x^12+x^11+x^8+1: b[t] = b[t-13]^b[t-12]^b[t-11]^b[t-8].
REQ-014 Block SHALL hold 13-bit history register h (h[0] newest); prediction p = h[12]^h[11]^h[10]^h[7]; on each valid bit h <= {h[11:0], x}.
REQ-015 FSM states SHALL be FILL, HUNT, LOCK; reset state FILL.
REQ-016 FILL: shift inbit into h, count valid bits; after the 13th valid bit go to HUNT with match counter 0; no comparison made.
REQ-017 HUNT: shift inbit into h; if inbit==p and h!=0, increment match counter; else match counter <= 0 (all-zero h never counts, avoiding zero lock-up).
REQ-018 HUNT: on the valid bit taking match counter to LOCK_CNT, go to LOCK; locked=1 from the following cycle.
REQ-019 LOCK: shift p (not inbit) into h, so a single line error is counted once and does not corrupt prediction.
REQ-020 LOCK: on each valid bit, bit_count +1; if inbit!=p then err_pulse=1 next cycle and err_count +1.
REQ-021 err_count and bit_count SHALL saturate at all-ones, never wrap.
REQ-022 LOCK: window counter counts valid bits 0..WIN-1 with window error counter; on reaching LOSS_ERRS errors in a window, go to FILL next cycle, locked=0, h cleared; at window end both counters restart at 0.
REQ-023 in_valid=0: no state, h, or counter change; err_pulse=0.
REQ-024 clr_cnt=1 SHALL zero err_count and bit_count; clear wins over a same-cycle increment; err_pulse and FSM unaffected.
REQ-025 Leaving LOCK SHALL not clear err_count/bit_count; they hold until clr_cnt or rst.
REQ-026 Latency: err_pulse and locked are registered, one cycle after the bit's in_valid cycle.

Reset
REQ-027 rst=1 SHALL force FILL, h=0, all internal counters 0, locked=0, err_pulse=0, err_count=0, bit_count=0, overriding all other inputs, including mid-lock.
REQ-028 First valid bit after rst deasserts SHALL be treated as fill bit 1.

Verification
REQ-029 Error-free PRBS, in_valid=1 every cycle -> locked rises one cycle after the 45th valid bit; err_count=0; bit_count=N-45 after N bits.
REQ-030 Locked, invert one bit -> exactly one err_pulse, err_count=1, locked stays 1.
REQ-031 Locked, 8 inverted bits within 64 -> locked=0 the cycle after the 8th; counters retained; relock after a further 45 clean bits.
REQ-032 Constant-zero input -> never locks; all outputs stay 0.
REQ-033 in_valid toggling 1/0 -> lock after 45 valid bits (~90 cycles); clr_cnt with a same-cycle error -> err_count=0, err_pulse=1.
REQ-034 rst pulse while locked with err_count=5 -> next cycle locked=0, err_count=0, bit_count=0, state FILL.
